// File: rtl/shapool_sequencer_if.sv
// rtl/shapool_sequencer_if.sv - host/pool signal bundle for the shapool job sequencer
//
// Purpose: groups the job-control inputs, the pool verdict and the sequencer
// outputs so they travel as one port.
// Modports:
//   master - host/pool side: drives start, abort, clear, nonce_start, hash_success.
//   slave  - sequencer side: drives shapool_reset, nonce, nonce_valid, busy,
//            success, exhausted, result_nonce.
interface shapool_sequencer_if #(
    parameter int NONCE_WIDTH  = 32,
    parameter int PREFIX_WIDTH = 8
);
    logic                    start;
    logic                    abort;
    logic                    clear;
    logic [PREFIX_WIDTH-1:0] nonce_start;
    logic                    hash_success;
    logic                    shapool_reset;
    logic [NONCE_WIDTH-1:0]  nonce;
    logic                    nonce_valid;
    logic                    busy;
    logic                    success;
    logic                    exhausted;
    logic [NONCE_WIDTH-1:0]  result_nonce;

    modport master (
        output start, abort, clear, nonce_start, hash_success,
        input  shapool_reset, nonce, nonce_valid, busy, success, exhausted, result_nonce
    );

    modport slave (
        input  start, abort, clear, nonce_start, hash_success,
        output shapool_reset, nonce, nonce_valid, busy, success, exhausted, result_nonce
    );
endinterface

// File: rtl/shapool_sequencer.sv
// rtl/shapool_sequencer.sv - job sequencer issuing nonces to the shapool hash pool
//
// Purpose: on start, releases the pool from reset and issues one nonce per
// clock as {prefix, counter}. Issued nonces are tracked through a LATENCY-deep
// delay line so a pool hit reports the exact winning nonce. Ends in DONE on a
// hit, on abort, or after the full counter range has drained.
// Ports:
//   clk   - core clock
//   reset - asynchronous active-high reset
//   bus   - shapool_sequencer_if.slave (control in, nonce/status out)
module shapool_sequencer #(
    parameter int NONCE_WIDTH  = 32,
    parameter int PREFIX_WIDTH = 8,
    parameter int LATENCY      = 4
) (
    input  logic                clk,
    input  logic                reset,
    shapool_sequencer_if.slave  bus
);
    localparam int COUNTER_WIDTH = NONCE_WIDTH - PREFIX_WIDTH;
    localparam int DW            = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state;
    state_t                   state_next;
    logic [PREFIX_WIDTH-1:0]  prefix;
    logic [COUNTER_WIDTH-1:0] counter;
    logic [DW-1:0]            drain_cnt;
    logic                     dl_valid [LATENCY];
    logic [NONCE_WIDTH-1:0]   dl_nonce [LATENCY];
    logic                     success_q;
    logic                     exhausted_q;
    logic [NONCE_WIDTH-1:0]   result_q;

    logic running;
    logic last_issue;
    logic hit;
    logic drain_done;
    logic accept_start;
    logic flush;

    assign running      = (state == RUN) || (state == DRAIN);
    // Range end is taken from the value being issued, not from the wrapped counter.
    assign last_issue   = (state == RUN) && (&counter);
    assign hit          = running && bus.hash_success && dl_valid[LATENCY-1];
    assign drain_done   = (state == DRAIN) && (drain_cnt == DW'(LATENCY - 1));
    assign accept_start = (state == IDLE) && bus.start && !bus.abort;
    // Flush on the edge that leaves RUN/DRAIN so a stale tap is never seen in DONE.
    assign flush        = (state_next == IDLE) || (state_next == DONE);

    assign bus.nonce         = {prefix, counter};
    assign bus.nonce_valid   = (state == RUN);
    assign bus.busy          = running;
    assign bus.shapool_reset = !running;
    assign bus.success       = success_q;
    assign bus.exhausted     = exhausted_q;
    assign bus.result_nonce  = result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept_start) state_next = RUN;
            RUN: begin
                if (hit || bus.abort) state_next = DONE;
                else if (last_issue)  state_next = DRAIN;
            end
            DRAIN: if (hit || bus.abort || drain_done) state_next = DONE;
            DONE:  if (bus.clear) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefix      <= '0;
            counter     <= '0;
            drain_cnt   <= '0;
            success_q   <= 1'b0;
            exhausted_q <= 1'b0;
            result_q    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_valid[i] <= 1'b0;
                dl_nonce[i] <= '0;
            end
        end else begin
            if (accept_start) begin
                prefix  <= bus.nonce_start;
                counter <= '0;
            end else if (state == RUN) begin
                counter <= counter + 1'b1;
            end

            if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                drain_cnt <= '0;

            if (flush) begin
                for (int i = 0; i < LATENCY; i++) dl_valid[i] <= 1'b0;
            end else begin
                dl_valid[0] <= bus.nonce_valid;
                dl_nonce[0] <= bus.nonce;
                for (int i = 1; i < LATENCY; i++) begin
                    dl_valid[i] <= dl_valid[i-1];
                    dl_nonce[i] <= dl_nonce[i-1];
                end
            end

            // Hit beats abort beats drain expiry; abort leaves all flags at 0.
            if (state == DONE && bus.clear) begin
                success_q   <= 1'b0;
                exhausted_q <= 1'b0;
                result_q    <= '0;
            end else if (hit) begin
                success_q <= 1'b1;
                result_q  <= dl_nonce[LATENCY-1];
            end else if (drain_done && !bus.abort) begin
                exhausted_q <= 1'b1;
            end
        end
    end
endmodule

// File: doc/shapool_sequencer.md
# shapool_sequencer

Job sequencer for the shapool hashing datapath, between the external IO/config block and the hash pool. Once a job is configured it starts the pool, issues one nonce per clock from a device-specific base, and tracks issued nonces through the pool's fixed pipeline latency. It reports the exact nonce that produced a success, so the host no longer applies an offset correction. It also detects exhaustion of the nonce range and handles host aborts.

## Interface
Parameters:
- `NONCE_WIDTH`, 32: width of the nonce presented to the pool.
- `PREFIX_WIDTH`, 8: width of `nonce_start`; forms the top bits of every nonce.
- `LATENCY`, 4: cycles from a nonce being issued to its `hash_success` verdict; legal range 1..64.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a job (honoured only in IDLE).
- `abort`  in  1  level; stops the job early.
- `clear`  in  1  single-cycle pulse; returns DONE to IDLE.
- `nonce_start`  in  PREFIX_WIDTH  device partition prefix; sampled on the accepted `start`.
- `hash_success`  in  1  verdict from the pool, aligned LATENCY cycles after issue.
- `shapool_reset`  out  1  holds the pool in reset while high.
- `nonce`  out  NONCE_WIDTH  nonce issued this cycle.
- `nonce_valid`  out  1  `nonce` is live this cycle.
- `busy`  out  1  high in RUN or DRAIN.
- `success`  out  1  job ended on a hit; held high in DONE.
- `exhausted`  out  1  full range issued with no hit; held high in DONE.
- `result_nonce`  out  NONCE_WIDTH  winning nonce; 0 unless `success`.

## Operation
- `COUNTER_WIDTH` = NONCE_WIDTH − PREFIX_WIDTH.
- `nonce` = {prefix register, counter}, where the counter is COUNTER_WIDTH bits.
- States and transitions:
  - IDLE → RUN on `start`.
  - RUN → DRAIN after the all-ones counter value is issued.
  - RUN or DRAIN → DONE on qualified success.
  - RUN or DRAIN → DONE on `abort`.
  - DRAIN → DONE after LATENCY cycles.
  - DONE → IDLE on `clear`.
- Delay line: LATENCY stages of {valid, nonce}, loaded each cycle with {`nonce_valid`, `nonce`}. The stage at the output end is the "tap".
- Qualified success is `hash_success` && tap valid. `hash_success` with tap valid = 0 is ignored.
- On qualified success: `result_nonce` ← tap nonce, `success` ← 1.
- DRAIN expiry without a hit: `exhausted` ← 1, `result_nonce` = 0.
- Abort: DONE with `success` = `exhausted` = 0 and `result_nonce` = 0.
- Priority in the same cycle: qualified success > abort > drain expiry.
- In IDLE, `abort` && `start` in the same cycle: remain in IDLE.
- `start` outside IDLE is ignored.
- `clear` outside DONE is ignored.
- `shapool_reset` = 1 in IDLE and DONE, 0 in RUN and DRAIN.
- The delay line is flushed (all valid = 0) whenever `shapool_reset` = 1.
- Counter arithmetic is modulo 2^COUNTER_WIDTH. The wrap is detected on the issued all-ones value, never by comparing after the increment.
- Reset values:
  - State is IDLE.
  - `shapool_reset` = 1.
  - All other outputs, the prefix register, the counter and the delay line are 0.

## Timing
- Accepted `start` at edge k:
  - Edge k+1: RUN entered, `nonce_valid` = 1, `nonce` = {nonce_start, 0}, `shapool_reset` = 0.
  - The counter then increments every cycle.
- Issue rate: one nonce per cycle with no bubbles; `nonce_valid` falls the cycle after the last value issues.
- Success latency: `hash_success` high on the cycle the tap holds nonce N → next cycle in DONE with `success` = 1, `result_nonce` = N, `nonce_valid` = 0.
- DRAIN lasts exactly LATENCY cycles. A hit on the final nonce still arrives within DRAIN and takes the success path.
- Abort is honoured on the cycle it is sampled; DONE follows on the next cycle.
- Flags `success` and `exhausted` are mutually exclusive, hold through DONE, and clear on entering IDLE.
- Asserting `reset` in any state forces the reset values immediately; no pending result survives.

## Test plan
- LATENCY = 4, start with `nonce_start` = 0xA5:
  - First `nonce_valid` cycle shows 0xA5000000; the next shows 0xA5000001.
  - `busy` = 1 and `shapool_reset` = 0 while running.
- Hit: pulse `hash_success` exactly 4 cycles after 0xA5000010 is issued → `success` = 1 and `result_nonce` = 0xA5000010 on the next cycle; `nonce_valid` = 0.
- Exhaustion, NONCE_WIDTH = 12, PREFIX_WIDTH = 8, `nonce_start` = 0x3:
  - Nonces 0x030..0x03F are issued, 16 valid cycles in total.
  - Then 4 DRAIN cycles follow → `exhausted` = 1, `result_nonce` = 0.
  - Same config with `hash_success` on the 4th DRAIN cycle → `success` = 1, `result_nonce` = 0x03F.
- `hash_success` pulsed 2 cycles after start, before the tap is valid → ignored, job continues. Then `abort` → DONE with all flags 0. `clear` → IDLE with `shapool_reset` = 1.
- Simultaneous events:
  - `abort` and qualified `hash_success` in the same cycle → `success` = 1.
  - `start` and `abort` in the same cycle in IDLE → stays IDLE.
- Async `reset` mid-RUN, not aligned to a `clk` edge → outputs reach reset values before the next edge. A subsequent `start` resumes from {prefix, 0}.
